// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, code table, frame FSM states.
package seg7_pkg;

    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_WAIT0,
        ST_COLLECT
    } frame_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } seg_dec_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Maps a 7-bit segment pattern back to its BCD nibble; blank decodes to F.
module seg_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output seg_dec_t   dec_c
);

    always_comb begin
        dec_c.valid  = 1'b1;
        dec_c.nibble = 4'h0;
        case (pattern)
            SEG_0:     dec_c.nibble = 4'd0;
            SEG_1:     dec_c.nibble = 4'd1;
            SEG_2:     dec_c.nibble = 4'd2;
            SEG_3:     dec_c.nibble = 4'd3;
            SEG_4:     dec_c.nibble = 4'd4;
            SEG_5:     dec_c.nibble = 4'd5;
            SEG_6:     dec_c.nibble = 4'd6;
            SEG_7:     dec_c.nibble = 4'd7;
            SEG_8:     dec_c.nibble = 4'd8;
            SEG_9:     dec_c.nibble = 4'd9;
            SEG_BLANK: dec_c.nibble = 4'hF;
            default:   dec_c.valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures multiplexed 7-segment scan frames back into BCD digits, with
// stability tracking and strobe/code/sequence error pulses.
module seg_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned STABLE_N   = 2
) (
    input  logic                    clk_1k,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   seg_com_in,
    input  logic [7:0]              seg_data_in,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic                    frame_stb,
    output logic                    stable,
    output logic                    com_err,
    output logic                    code_err,
    output logic                    seq_err
);

    localparam int unsigned POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] MATCH_MAX = CNT_W'(STABLE_N - 1);

    logic [NUM_DIGITS-1:0]   com_q;
    logic [7:0]              data_q;
    frame_state_e            state_q, state_d;
    logic [POS_W-1:0]        exp_q, exp_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, frame_dig_c;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, frame_dp_c;
    logic [CNT_W-1:0]        match_q, match_d_c;
    seg_dec_t                dec_c;
    logic [NUM_DIGITS-1:0]   com_n_c;
    logic [POS_W-1:0]        pos_c;
    logic idle_c, onehot_c, com_bad_c, code_bad_c, sample_ok_c;
    logic wr_c, done_c, seq_bad_c, same_c;

    seg_pattern_decode u_decode (
        .pattern (data_q[SEG_G:SEG_A]),
        .dec_c   (dec_c)
    );

    // Strobe classification and one-hot position encode
    always_comb begin
        com_n_c  = ~com_q;
        idle_c   = (com_q == '0) || (com_q == '1);
        onehot_c = $onehot(com_n_c);
        pos_c    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (com_n_c[i]) pos_c = POS_W'(i);
        end
        com_bad_c   = !idle_c && !onehot_c;
        code_bad_c  = !idle_c && !dec_c.valid;
        sample_ok_c = !idle_c && onehot_c && dec_c.valid;
    end

    always_ff @(posedge clk_1k or negedge reset) begin
        if (!reset) begin
            state_q <= ST_WAIT0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
        end
    end

    // Frame sequencing: position 0 opens a frame, positions must then advance by one
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        wr_c      = 1'b0;
        seq_bad_c = 1'b0;
        unique case (state_q)
            ST_WAIT0: begin
                if (sample_ok_c && pos_c == '0) begin
                    wr_c    = 1'b1;
                    exp_d   = POS_W'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (sample_ok_c) begin
                    if (pos_c == exp_q) begin
                        wr_c  = 1'b1;
                        exp_d = exp_q + POS_W'(1);
                    end else begin
                        seq_bad_c = 1'b1;
                        if (pos_c == '0) begin
                            wr_c  = 1'b1;
                            exp_d = POS_W'(1);
                        end else begin
                            state_d = ST_WAIT0;
                        end
                    end
                end
            end
            default: state_d = ST_WAIT0;
        endcase
        if (com_bad_c || code_bad_c) state_d = ST_WAIT0;
        done_c = wr_c && (pos_c == LAST_POS);
        if (done_c) state_d = ST_WAIT0;

        frame_dig_c = shadow_dig_q;
        frame_dp_c  = shadow_dp_q;
        frame_dig_c[4*pos_c +: 4] = dec_c.nibble;
        frame_dp_c[pos_c]         = data_q[SEG_DP];

        same_c = (frame_dig_c == digits) && (frame_dp_c == dp);
        if (!same_c)                match_d_c = '0;
        else if (match_q == MATCH_MAX) match_d_c = match_q;
        else                        match_d_c = match_q + CNT_W'(1);
    end

    // Input, shadow and output registers
    always_ff @(posedge clk_1k or negedge reset) begin
        if (!reset) begin
            com_q        <= '1;
            data_q       <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            digits       <= '0;
            dp           <= '0;
            match_q      <= '0;
            stable       <= 1'b0;
            frame_stb    <= 1'b0;
            com_err      <= 1'b0;
            code_err     <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            com_q     <= seg_com_in;
            data_q    <= seg_data_in;
            frame_stb <= done_c;
            com_err   <= com_bad_c;
            code_err  <= code_bad_c;
            seq_err   <= seq_bad_c;
            if (wr_c) begin
                shadow_dig_q <= frame_dig_c;
                shadow_dp_q  <= frame_dp_c;
            end
            if (done_c) begin
                digits  <= frame_dig_c;
                dp      <= frame_dp_c;
                match_q <= match_d_c;
                stable  <= (match_d_c == MATCH_MAX);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: a frame-level reference model queues
// expected events; a negedge monitor compares them against the DUT outputs.
module tb_seg_scan_capture;

    localparam int N        = 8;
    localparam int STABLE_N = 2;

    logic        clk_1k = 1'b0;
    logic        reset  = 1'b1;
    logic [7:0]  com    = 8'hFF;
    logic [7:0]  data   = 8'h00;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic        frame_stb, stable, com_err, code_err, seq_err;

    seg_scan_capture #(.NUM_DIGITS(N), .STABLE_N(STABLE_N)) dut (
        .clk_1k      (clk_1k),
        .reset       (reset),
        .seg_com_in  (com),
        .seg_data_in (data),
        .digits      (digits),
        .dp          (dp),
        .frame_stb   (frame_stb),
        .stable      (stable),
        .com_err     (com_err),
        .code_err    (code_err),
        .seq_err     (seq_err)
    );

    always #5 clk_1k = ~clk_1k;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk_1k) cyc++;

    typedef struct {
        int          stamp;
        logic [31:0] dig;
        logic [7:0]  dpv;
        logic        stb;
    } frame_ev_t;
    typedef struct {
        int         stamp;
        logic [2:0] flags;   // {com, code, seq}
    } err_ev_t;

    frame_ev_t fq[$];
    err_ev_t   eq[$];

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model state
    int          m_next;          // -1: waiting for position 0
    logic [3:0]  m_sh  [N];
    logic        m_shdp[N];
    logic [31:0] m_prev_dig;
    logic [7:0]  m_prev_dp;
    int          m_match;
    logic [31:0] cur_dig;
    logic [7:0]  cur_dp;
    logic        cur_stb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        if (p == 7'h00) return 15;
        for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_next     = -1;
        m_prev_dig = '0;
        m_prev_dp  = '0;
        m_match    = 0;
        cur_dig    = '0;
        cur_dp     = '0;
        cur_stb    = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_sh[i]   = '0;
            m_shdp[i] = 1'b0;
        end
    endtask

    task automatic model_write(input int pos, input int nib, input logic dpb, input int stamp);
        frame_ev_t fe;
        m_sh[pos]   = 4'(nib);
        m_shdp[pos] = dpb;
        m_next      = pos + 1;
        if (pos == N - 1) begin
            for (int i = 0; i < N; i++) begin
                fe.dig[4*i +: 4] = m_sh[i];
                fe.dpv[i]        = m_shdp[i];
            end
            if (fe.dig == m_prev_dig && fe.dpv == m_prev_dp)
                m_match = (m_match + 1 > STABLE_N - 1) ? STABLE_N - 1 : m_match + 1;
            else
                m_match = 0;
            fe.stb     = (m_match == STABLE_N - 1);
            fe.stamp   = stamp;
            m_prev_dig = fe.dig;
            m_prev_dp  = fe.dpv;
            m_next     = -1;
            fq.push_back(fe);
        end
    endtask

    // One scan sample, applied at the next posedge; its effects show one edge later
    task automatic model_step(input logic [7:0] c, input logic [7:0] d);
        int zeros, pos, nib, stamp;
        err_ev_t ee;
        stamp = cyc + 2;
        zeros = 0;
        pos   = 0;
        for (int i = 0; i < N; i++) if (!c[i]) begin zeros++; pos = i; end
        if (zeros == 0 || zeros == N) return;
        nib = lookup(d[6:0]);
        if (zeros != 1 || nib < 0) begin
            ee.stamp = stamp;
            ee.flags = {zeros != 1, nib < 0, 1'b0};
            eq.push_back(ee);
            m_next = -1;
            return;
        end
        if (m_next < 0) begin
            if (pos == 0) model_write(0, nib, d[7], stamp);
        end else if (pos == m_next) begin
            model_write(pos, nib, d[7], stamp);
        end else begin
            ee.stamp = stamp;
            ee.flags = 3'b001;
            eq.push_back(ee);
            if (pos == 0) model_write(0, nib, d[7], stamp);
            else          m_next = -1;
        end
    endtask

    // Monitor: compare every cycle against the head of the scoreboard queues
    always @(negedge clk_1k) begin
        if (!reset) begin
            check("reset_outputs",
                  {digits, dp, frame_stb, stable, com_err, code_err, seq_err}, 64'd0);
        end else begin
            logic       exp_f;
            logic [2:0] exp_e;
            exp_f = (fq.size() > 0) && (fq[0].stamp == cyc);
            check("frame_stb", frame_stb, exp_f);
            if (exp_f) begin
                frame_ev_t fe;
                fe      = fq.pop_front();
                cur_dig = fe.dig;
                cur_dp  = fe.dpv;
                cur_stb = fe.stb;
            end
            check("digits", digits, cur_dig);
            check("dp", dp, cur_dp);
            check("stable", stable, cur_stb);
            exp_e = 3'b000;
            if (eq.size() > 0 && eq[0].stamp == cyc) begin
                err_ev_t ee;
                ee    = eq.pop_front();
                exp_e = ee.flags;
            end
            check("err_flags{com,code,seq}", {com_err, code_err, seq_err}, exp_e);
        end
    end

    task automatic drive_raw(input logic [7:0] c, input logic [7:0] d);
        @(negedge clk_1k);
        com  = c;
        data = d;
        if (reset) model_step(c, d);
    endtask

    task automatic drive_pos(input int p, input logic [3:0] nib, input logic dpb);
        logic [6:0] code;
        code = (nib > 4'd9) ? 7'h00 : seg_tab[nib];
        drive_raw(~(8'(1) << p), {dpb, code});
    endtask

    task automatic idle(input int n);
        repeat (n) drive_raw(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, 8'($urandom));
    endtask

    task automatic send_frame(input logic [31:0] v, input logic [7:0] dps);
        for (int p = 0; p < N; p++) drive_pos(p, v[4*p +: 4], dps[p]);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_1k);
        #1 reset = 1'b0;
        model_reset();
        repeat (n) begin
            @(negedge clk_1k);
            com  = 8'($urandom);
            data = 8'($urandom);
        end
        @(negedge clk_1k);
        com = 8'hFF;
        #1 reset = 1'b1;
    endtask

    logic [31:0] rv, prev_rv;
    logic [7:0]  rdp, prev_rdp;

    initial begin
        model_reset();
        #1 reset = 1'b0;
        // Reset held with toggling inputs, then release
        do_reset(6);
        idle(3);

        // Basic frame, repeat for stability, then one digit changed
        send_frame(32'h8765_4321, 8'h00);
        send_frame(32'h8765_4321, 8'h00);
        send_frame(32'h8705_4321, 8'h00);
        idle(2);

        // Bad strobe mid-frame aborts it; next frame is clean
        for (int p = 0; p < 5; p++) drive_pos(p, 4'(p), 1'b0);
        drive_raw(8'b1101_1101, {1'b0, seg_tab[5]});
        drive_pos(6, 4'd6, 1'b0);
        drive_pos(7, 4'd7, 1'b0);
        send_frame(32'h1122_3344, 8'h81);

        // Bad code aborts; blank decodes to F; dp carried through
        drive_pos(0, 4'd9, 1'b0);
        drive_pos(1, 4'd9, 1'b0);
        drive_raw(~8'b0000_0100, 8'h49);
        for (int p = 3; p < N; p++) drive_pos(p, 4'd9, 1'b0);
        send_frame(32'h9999_9F99, 8'h00);
        send_frame(32'h1234_5067, 8'h04);
        idle(1);

        // Skipped position; restart at 0 mid-frame
        for (int p = 0; p < 3; p++) drive_pos(p, 4'd3, 1'b0);
        drive_pos(4, 4'd3, 1'b0);
        for (int p = 5; p < N; p++) drive_pos(p, 4'd3, 1'b0);
        drive_pos(0, 4'd1, 1'b0);
        drive_pos(1, 4'd1, 1'b0);
        send_frame(32'h0000_0000, 8'hFF);

        // Reset mid-frame discards the partial frame
        idle(3);
        for (int p = 0; p < 4; p++) drive_pos(p, 4'd8, 1'b1);
        do_reset(2);
        for (int p = 4; p < N; p++) drive_pos(p, 4'd8, 1'b1);
        send_frame(32'h5555_5555, 8'h00);

        // Randomized frames with occasional injected faults
        prev_rv  = 32'h5555_5555;
        prev_rdp = 8'h00;
        repeat (80) begin
            int mode, k;
            mode = $urandom_range(0, 7);
            k    = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) != 0) begin
                rv  = prev_rv;
                rdp = prev_rdp;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int r;
                    r = $urandom_range(0, 10);
                    rv[4*i +: 4] = (r == 10) ? 4'hF : 4'(r);
                end
                rdp = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            end
            prev_rv  = rv;
            prev_rdp = rdp;
            for (int p = 0; p < N; p++) begin
                if (p == k && mode == 1) begin
                    if ($urandom_range(0, 1) != 0)
                        drive_raw(8'($urandom), {rdp[p], seg_tab[$urandom_range(0, 9)]});
                    else
                        drive_raw(~((8'(1) << p) | (8'(1) << ((p + 1 + $urandom_range(0, 6)) % N))),
                                  {rdp[p], seg_tab[0]});
                end else if (p == k && mode == 2) begin
                    drive_raw(~(8'(1) << p), 8'($urandom));
                end else if (p == k && mode == 3) begin
                    // skip this position
                end else if (p == k && mode == 4) begin
                    drive_pos(p, rv[4*p +: 4], rdp[p]);
                    drive_pos(p, rv[4*p +: 4], rdp[p]);
                end else if (p == k && mode == 5) begin
                    idle($urandom_range(1, 2));
                    drive_pos(p, rv[4*p +: 4], rdp[p]);
                end else begin
                    drive_pos(p, rv[4*p +: 4], rdp[p]);
                end
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(4);
        check("frames_drained", 64'(fq.size()), 64'd0);
        check("errors_drained", 64'(eq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
